// File: rtl/inst_rom_resp.sv
// Instruction ROM responder: returns a 32-bit word per fetch after a configurable number of
// wait states. The word array is written through a program port and flags bad fetches as faults.
module inst_rom_resp #(
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic [31:0]           addr,
  output logic [31:0]           inst,
  output logic                  inst_valid,
  output logic                  fault,
  output logic                  busy,
  input  logic                  prog_we,
  input  logic [DEPTH_LOG2-1:0] prog_addr,
  input  logic [31:0]           prog_data
);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES - 1);

  logic [31:0] r_mem [1 << DEPTH_LOG2];

  state_t                r_state;
  logic [3:0]            r_cnt;
  logic [DEPTH_LOG2-1:0] r_idx;
  logic                  r_err;
  logic [31:0]           r_inst;
  logic                  r_inst_valid;
  logic                  r_fault;
  logic                  r_busy;

  logic [DEPTH_LOG2-1:0] w_req_idx;
  logic                  w_req_err;
  logic                  w_accept;
  logic                  w_load;
  logic [DEPTH_LOG2-1:0] w_ld_idx;
  logic                  w_ld_err;
  logic [31:0]           w_rd_data;

  assign w_req_idx = addr[DEPTH_LOG2+1:2];
  assign w_req_err = (addr[1:0] != 2'b00) || ((addr >> (DEPTH_LOG2 + 2)) != 32'd0);
  assign w_accept  = ce && (r_state != StWait);

  // A response is loaded either when the wait count expires or directly on a zero-wait accept.
  assign w_load    = ((r_state == StWait) && (r_cnt == 4'd0)) ||
                     (w_accept && (WAIT_CYCLES == 0));
  assign w_ld_idx  = (r_state == StWait) ? r_idx : w_req_idx;
  assign w_ld_err  = (r_state == StWait) ? r_err : w_req_err;

  // Write-first bypass for a program write landing on the word being loaded.
  assign w_rd_data = (prog_we && (prog_addr == w_ld_idx)) ? prog_data : r_mem[w_ld_idx];

  always_ff @(posedge clk) begin
    if (prog_we) begin
      r_mem[prog_addr] <= prog_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= StIdle;
      r_cnt        <= 4'd0;
      r_idx        <= '0;
      r_err        <= 1'b0;
      r_inst       <= 32'd0;
      r_inst_valid <= 1'b0;
      r_fault      <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_inst_valid <= 1'b0;
      r_fault      <= 1'b0;
      if (w_load) begin
        r_state      <= StResp;
        r_busy       <= 1'b0;
        r_inst_valid <= 1'b1;
        r_fault      <= w_ld_err;
        r_inst       <= w_ld_err ? 32'd0 : w_rd_data;
      end else if (r_state == StWait) begin
        r_cnt <= r_cnt - 4'd1;
      end else if (w_accept) begin
        r_state <= StWait;
        r_cnt   <= WAIT_INIT;
        r_busy  <= 1'b1;
        r_idx   <= w_req_idx;
        r_err   <= w_req_err;
      end else begin
        r_state <= StIdle;
      end
    end
  end

  assign inst       = r_inst;
  assign inst_valid = r_inst_valid;
  assign fault      = r_fault;
  assign busy       = r_busy;

endmodule

// File: tb/tb_inst_rom_resp.sv
// Bench for inst_rom_resp: zero-wait and three-wait instances share stimulus and are compared
// every cycle against a countdown/array reference model, plus directed boundary checks.
module tb_inst_rom_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic [31:0] addr;
  logic        prog_we;
  logic [9:0]  prog_addr;
  logic [31:0] prog_data;

  logic [31:0] inst0, inst3;
  logic        valid0, valid3, fault0, fault3, busy0, busy3;

  int n_pass  = 0;
  int n_total = 0;

  inst_rom_resp #(.DEPTH_LOG2(10), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .ce(ce), .addr(addr), .inst(inst0), .inst_valid(valid0),
    .fault(fault0), .busy(busy0), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data)
  );

  inst_rom_resp #(.DEPTH_LOG2(10), .WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .rst(rst), .ce(ce), .addr(addr), .inst(inst3), .inst_valid(valid3),
    .fault(fault3), .busy(busy3), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data)
  );

  always #5 clk = ~clk;

  // Reference model: per instance, edges remaining until the response, plus the expected outputs.
  logic [31:0] mem_m [1024];
  int          m_wait   [2] = '{0, 3};
  int          m_left   [2];
  int          m_pidx   [2];
  bit          m_perr   [2];
  logic [31:0] e_inst   [2];
  bit          e_valid  [2];
  bit          e_fault  [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_left[d] = 0; e_inst[d] = 0; e_valid[d] = 0; e_fault[d] = 0;
    end
  endtask

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      bit resp = 0;
      int idx  = 0;
      bit err  = 0;
      if (m_left[d] > 0) begin
        m_left[d]--;
        if (m_left[d] == 0) begin
          resp = 1; idx = m_pidx[d]; err = m_perr[d];
        end
      end else if (ce) begin
        err = (addr % 4 != 0) || (addr >= 32'd4096);
        idx = int'(addr / 4) % 1024;
        if (m_wait[d] == 0) resp = 1;
        else begin
          m_left[d] = m_wait[d]; m_pidx[d] = idx; m_perr[d] = err;
        end
      end
      e_valid[d] = resp;
      e_fault[d] = resp && err;
      if (resp) begin
        if (err) e_inst[d] = 0;
        else if (prog_we && int'(prog_addr) == idx) e_inst[d] = prog_data;
        else e_inst[d] = mem_m[idx];
      end
    end
    if (prog_we) mem_m[prog_addr] = prog_data;
  endtask

  task automatic check_all();
    chk("w0_valid", {31'd0, valid0}, {31'd0, e_valid[0]});
    chk("w0_fault", {31'd0, fault0}, {31'd0, e_fault[0]});
    chk("w0_busy",  {31'd0, busy0},  32'd0);
    chk("w0_inst",  inst0, e_inst[0]);
    chk("w3_valid", {31'd0, valid3}, {31'd0, e_valid[1]});
    chk("w3_fault", {31'd0, fault3}, {31'd0, e_fault[1]});
    chk("w3_busy",  {31'd0, busy3},  {31'd0, m_left[1] > 0});
    chk("w3_inst",  inst3, e_inst[1]);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    ce = 0; prog_we = 0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst = 0; ce = 0; addr = 0; prog_we = 0; prog_addr = 0; prog_data = 0;
    model_reset();
    #1;
    chk("rst_valid", {30'd0, valid0, valid3}, 32'd0);
    chk("rst_busy",  {30'd0, busy0, busy3}, 32'd0);
    chk("rst_inst",  inst0 | inst3, 32'd0);
    #12 rst = 1;

    // Preload the whole array so every fetch has a defined value.
    for (int i = 0; i < 1024; i++) begin
      prog_we = 1; prog_addr = 10'(i);
      prog_data = (i < 4) ? 32'h11111111 * (i + 1) : $urandom;
      tick();
    end
    idle(1);

    // Back-to-back zero-wait fetches.
    ce = 1;
    for (int i = 0; i < 4; i++) begin
      addr = 32'(i * 4);
      tick();
      chk("b2b_valid", {31'd0, valid0}, 32'd1);
      chk("b2b_inst",  inst0, 32'h11111111 * (i + 1));
    end
    idle(5);

    // Three wait states; a request during busy is ignored.
    ce = 1; addr = 32'h8;
    tick();
    chk("w3_busy_n1", {31'd0, busy3}, 32'd1);
    addr = 32'hC;
    tick();
    chk("w3_busy_n2", {31'd0, busy3}, 32'd1);
    ce = 0;
    tick();
    chk("w3_busy_n3", {31'd0, busy3}, 32'd1);
    chk("w3_early",   {31'd0, valid3}, 32'd0);
    tick();
    chk("w3_resp_v",  {31'd0, valid3}, 32'd1);
    chk("w3_resp_d",  inst3, 32'h33333333);
    idle(6);
    chk("w3_c_unans", {31'd0, valid3}, 32'd0);

    // Misaligned and out-of-range fetches.
    ce = 1; addr = 32'h6;
    tick();
    chk("mis_fault", {31'd0, fault0}, 32'd1);
    chk("mis_inst",  inst0, 32'd0);
    idle(5);
    ce = 1; addr = 32'h00001000;
    tick();
    chk("oor_fault", {31'd0, fault0}, 32'd1);
    chk("oor_inst",  inst0, 32'd0);
    idle(5);

    // Program write colliding with the load of the same word.
    ce = 1; addr = 32'h8; prog_we = 1; prog_addr = 10'd2; prog_data = 32'hDEADBEEF;
    tick();
    chk("coll_inst", inst0, 32'hDEADBEEF);
    idle(5);

    // Asynchronous reset while waiting.
    ce = 1; addr = 32'h0;
    tick();
    ce = 0;
    tick();
    #3 rst = 0;
    #1;
    model_reset();
    chk("arst_busy",  {30'd0, busy0, busy3}, 32'd0);
    chk("arst_valid", {30'd0, valid0, valid3}, 32'd0);
    chk("arst_fault", {30'd0, fault0, fault3}, 32'd0);
    chk("arst_inst",  inst0 | inst3, 32'd0);
    #2 rst = 1;
    idle(6);
    ce = 1; addr = 32'h0;
    tick();
    chk("post_rst_w0", inst0, 32'h11111111);
    idle(4);
    chk("post_rst_w3", inst3, 32'h11111111);
    idle(2);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      int sel = int'($urandom % 8);
      ce = 1'($urandom % 2);
      if (sel < 6)       addr = ($urandom % 1024) * 4;
      else if (sel == 6) addr = ($urandom % 4096) | 32'h1 << ($urandom % 2);
      else               addr = $urandom | 32'h00001000;
      prog_we   = ($urandom % 4) == 0;
      prog_addr = ($urandom % 2 == 0) ? addr[11:2] : 10'($urandom);
      prog_data = $urandom;
      tick();
    end
    idle(5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
